key_conditioner: RTL

- Parametrised, multi-channel conditioner for board push-buttons and switches. Used between the board pins (KEY/SW) and the design top.
- Per channel it provides:
  - 2-FF synchronisation;
  - counter-based debounce;
  - one-cycle press/release pulses;
  - long-press detection;
  - optional auto-repeat.
- Supersedes single-channel debouncers; one instance serves all keys.

---
 rtl/key_conditioner_if.sv | 62 ++++++
 rtl/key_conditioner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_conditioner_if
//
// Purpose:
//    Bundles the per-channel key pins, the repeat enables and all conditioned
//    outputs of key_conditioner into one interface. Each vector is N_CH bits
//    wide, with bit n belonging to channel n.
//
// Signals:
//    i_key        raw asynchronous pins
//    i_repeat_en  per-channel auto-repeat enable
//    o_level      debounced pressed level (1 = pressed)
//    o_press      one-cycle pulse on debounced press
//    o_release    one-cycle pulse on debounced release
//    o_long       one-cycle pulse when the hold time reaches the long threshold
//    o_repeat     one-cycle pulse every repeat interval after a long press
//    dbg_state    per-channel FSM state, 2 bits per channel
//                 (bits [2n+1:2n] belong to channel n)
//
// Modports:
//    master  drives the pins and enables; observes the outputs (board/bench)
//    slave   the conditioner itself
//
// Handshake:
//    None. Every output is a plain registered level or a one-cycle pulse,
//    sampled on i_clk. There is no valid/ready flow control, so a consumer
//    must look at the pulses on every cycle or it will miss them.
// -----------------------------------------------------------------------------
interface key_conditioner_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0]   i_key;
   logic [N_CH-1:0]   i_repeat_en;
   logic [N_CH-1:0]   o_level;
   logic [N_CH-1:0]   o_press;
   logic [N_CH-1:0]   o_release;
   logic [N_CH-1:0]   o_long;
   logic [N_CH-1:0]   o_repeat;
   logic [2*N_CH-1:0] dbg_state;

   modport master (
      output i_key,
      output i_repeat_en,
      input  o_level,
      input  o_press,
      input  o_release,
      input  o_long,
      input  o_repeat,
      input  dbg_state
   );

   modport slave (
      input  i_key,
      input  i_repeat_en,
      output o_level,
      output o_press,
      output o_release,
      output o_long,
      output o_repeat,
      output dbg_state
   );
endinterface

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Purpose:
//    Multi-channel push-button / switch conditioner. For each channel it
//    provides:
//      - a 2-FF synchroniser;
//      - a counter-based debouncer;
//      - one-cycle press and release pulses;
//      - long-press detection;
//      - optional auto-repeat.
//    Channels are fully independent of each other.
//
// Ports:
//    i_clk   system clock; the only clock domain in this block
//    i_rst   asynchronous, active-high reset
//    bus     key_conditioner_if.slave
//              inputs:  i_key, i_repeat_en
//              outputs: o_level, o_press, o_release, o_long, o_repeat,
//                       dbg_state
//
// Timing:
//    Call edge 0 the first clock edge that samples a new pin value.
//      - sync2 takes the new value at edge 1.
//      - o_level and the press/release pulse update at edge
//        DEBOUNCE_CYCLES+1.
//      - o_long fires LONG_CYCLES edges after o_press.
//      - o_repeat then fires every REPEAT_CYCLES edges, counted only while
//        i_repeat_en is high.
// -----------------------------------------------------------------------------
module key_conditioner #(
   parameter int N_CH            = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   key_conditioner_if.slave bus
);

   // Every counter is wide enough to hold its limit.
   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LONG_W = $clog2(LONG_CYCLES + 1);
   localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

   // A counter event happens on the edge where the counter would otherwise
   // step onto its limit. Comparing against limit-1 keeps the pulse on that
   // same edge.
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
   localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

   // Raw pin level that means "released". The synchronisers reset to this
   // value so that reset itself never looks like a key edge.
   localparam logic RAW_RELEASED = ACTIVE_LOW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } state_t;

   logic [N_CH-1:0]   level_vec;
   logic [N_CH-1:0]   press_vec;
   logic [N_CH-1:0]   release_vec;
   logic [N_CH-1:0]   long_vec;
   logic [N_CH-1:0]   repeat_vec;
   logic [2*N_CH-1:0] state_vec;

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch

      // ------------------------------------------------------------------
      // Synchroniser and debouncer
      // ------------------------------------------------------------------
      logic             sync1_q;
      logic             sync2_q;
      logic             pressed_sync;
      logic             level_q;
      logic             level_d;
      logic [DEB_W-1:0] deb_cnt_q;
      logic [DEB_W-1:0] deb_cnt_d;
      logic             rise_evt;
      logic             fall_evt;
      logic             press_q;
      logic             release_q;

      // Polarity is normalised only after the second flop, so both
      // synchroniser stages carry the raw pin value.
      assign pressed_sync = sync2_q ^ ACTIVE_LOW;

      always_comb begin
         deb_cnt_d = '0;
         level_d   = level_q;
         rise_evt  = 1'b0;
         fall_evt  = 1'b0;
         if (pressed_sync != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
               // The input has differed for long enough: accept the new
               // level. The counter goes back to 0 (default above).
               level_d  = ~level_q;
               rise_evt = ~level_q;
               fall_evt = level_q;
            end else begin
               deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
         end
         // When the input matches o_level the counter stays cleared, so any
         // glitch shorter than DEBOUNCE_CYCLES is lost. The counter cannot
         // run past DEB_LAST, so it never wraps.
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            sync1_q   <= RAW_RELEASED;
            sync2_q   <= RAW_RELEASED;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            sync1_q   <= bus.i_key[ch];
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= rise_evt;
            release_q <= fall_evt;
         end
      end

      // ------------------------------------------------------------------
      // Hold / long-press / auto-repeat FSM
      // ------------------------------------------------------------------
      state_t            state_q;
      state_t            state_d;
      logic [LONG_W-1:0] hold_q;
      logic [LONG_W-1:0] hold_d;
      logic [REP_W-1:0]  rep_q;
      logic [REP_W-1:0]  rep_d;
      logic              long_q;
      logic              long_d;
      logic              repeat_q;
      logic              repeat_d;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            rep_q    <= '0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
         end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rep_q    <= rep_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
         end
      end

      // The FSM acts on the debouncer's combinational events. This keeps it
      // aligned with the edge on which o_press/o_release are registered. A
      // release seen in HELD or LONG is checked first, so a long or repeat
      // pulse due on that same edge is dropped.
      always_comb begin
         state_d  = state_q;
         hold_d   = hold_q;
         rep_d    = rep_q;
         long_d   = 1'b0;
         repeat_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rise_evt) begin
                  state_d = ST_HELD;
                  hold_d  = '0;
                  rep_d   = '0;
               end
            end
            ST_HELD: begin
               if (fall_evt) begin
                  state_d = ST_IDLE;
                  hold_d  = '0;
                  rep_d   = '0;
               end else if (hold_q == LONG_LAST) begin
                  // The hold counter parks at its limit. Because the FSM
                  // leaves HELD here, o_long can fire only once per press.
                  long_d  = 1'b1;
                  state_d = ST_LONG;
                  hold_d  = LONG_MAX;
                  rep_d   = '0;
               end else begin
                  hold_d = hold_q + LONG_W'(1);
               end
            end
            ST_LONG: begin
               if (fall_evt) begin
                  state_d = ST_IDLE;
                  hold_d  = '0;
                  rep_d   = '0;
               end else if (!bus.i_repeat_en[ch]) begin
                  // Held at 0, so re-enabling starts a full interval.
                  rep_d = '0;
               end else if (rep_q == REP_LAST) begin
                  repeat_d = 1'b1;
                  rep_d    = '0;
               end else begin
                  rep_d = rep_q + REP_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               hold_d  = '0;
               rep_d   = '0;
            end
         endcase
      end

      assign level_vec[ch]         = level_q;
      assign press_vec[ch]         = press_q;
      assign release_vec[ch]       = release_q;
      assign long_vec[ch]          = long_q;
      assign repeat_vec[ch]        = repeat_q;
      assign state_vec[2*ch +: 2]  = state_q;

      // Channel invariants
      a_press_release_excl : assert property (
         @(posedge i_clk) disable iff (i_rst) !(press_q && release_q));
      a_repeat_in_long : assert property (
         @(posedge i_clk) disable iff (i_rst) repeat_q |-> (state_q == ST_LONG));
      a_long_in_long : assert property (
         @(posedge i_clk) disable iff (i_rst) long_q |-> (state_q == ST_LONG));
   end

   assign bus.o_level   = level_vec;
   assign bus.o_press   = press_vec;
   assign bus.o_release = release_vec;
   assign bus.o_long    = long_vec;
   assign bus.o_repeat  = repeat_vec;
   assign bus.dbg_state = state_vec;

endmodule
